// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle cover collector: default sizes,
// the hit counter width and the two-state monitoring enum.
package toggle_cover_pkg;

   localparam int DEFAULT_WIDTH         = 16;
   localparam int DEFAULT_MAX_PER_CYCLE = 2;
   localparam int HIT_W                 = 16;

   typedef enum logic {
      BASELINE = 1'b0,
      RUN      = 1'b1
   } state_e;

endpackage

// File: rtl/toggle_cover_collector_pick_lowest.sv
// toggle_pick_lowest: purely combinational selection of up to N of the
// lowest-index set bits of a W-bit vector. Higher bits stay unselected and
// are left for later cycles by the caller.
module toggle_pick_lowest #(
   parameter int W = 8,
   parameter int N = 2
) (
   input  logic [W-1:0] vec,
   output logic [W-1:0] sel
);

   int taken;

   // Scan from bit 0 upward, granting bits until N have been taken.
   always_comb begin
      sel   = '0;
      taken = 0;
      for (int i = 0; i < W; i++) begin
         if (vec[i] && (taken < N)) begin
            sel[i] = 1'b1;
            taken  = taken + 1;
         end
      end
   end

endmodule

// File: rtl/toggle_cover_collector.sv
// toggle_cover_collector: watches a signal vector for rising and falling
// edges, queues each as a cover point (rise of bit i at 2i, fall at 2i+1)
// and drains the queue at most MAX_PER_CYCLE points per cycle as one-cycle
// pulses on valid, while counting every emitted pulse in hit_count.
// Optional build macro: TOGGLE_COVER_ONCE_EN -- adds a covered mask so each
// cover point is reported at most once until clear or reset.
module toggle_cover_collector
   import toggle_cover_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int MAX_PER_CYCLE = DEFAULT_MAX_PER_CYCLE
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     sig,
   output logic [2*WIDTH-1:0]   valid,
   output logic                 busy,
   output logic [HIT_W-1:0]     hit_count
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     prev_q, prev_d;
   logic [2*WIDTH-1:0]   pending_q, pending_d;
   logic [2*WIDTH-1:0]   valid_q, valid_d;
   logic [HIT_W-1:0]     hit_count_q, hit_count_d;
`ifdef TOGGLE_COVER_ONCE_EN
   logic [2*WIDTH-1:0]   covered_q, covered_d;
`endif

   logic [WIDTH-1:0]     rise, fall;
   logic [2*WIDTH-1:0]   new_raw, new_ev, sel;
   logic [HIT_W-1:0]     pulse_cnt;
   logic [HIT_W:0]       hit_sum;

   toggle_pick_lowest #(
      .W (2*WIDTH),
      .N (MAX_PER_CYCLE)
   ) u_pick (
      .vec (pending_q),
      .sel (sel)
   );

   // Edge detection is only meaningful once a baseline has been captured,
   // so nothing is reported in BASELINE or while monitoring is disabled.
   always_comb begin
      rise    = '0;
      fall    = '0;
      new_raw = '0;
      if ((state_q == RUN) && en) begin
         rise = sig & ~prev_q;
         fall = ~sig & prev_q;
      end
      for (int i = 0; i < WIDTH; i++) begin
         new_raw[2*i]   = rise[i];
         new_raw[2*i+1] = fall[i];
      end
`ifdef TOGGLE_COVER_ONCE_EN
      new_ev = new_raw & ~covered_q;
`else
      new_ev = new_raw;
`endif
   end

   // Count the pulses currently on valid and add them with saturation.
   always_comb begin
      pulse_cnt = '0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         pulse_cnt = pulse_cnt + {{(HIT_W-1){1'b0}}, valid_q[i]};
      end
      hit_sum = {1'b0, hit_count_q} + {1'b0, pulse_cnt};
   end

   // Next-state logic. A re-detected point that is also being emitted this
   // cycle stays pending, so it is reported again. Clear flushes the queue
   // and counters but lets state/prev advance normally, so a toggle seen
   // during the clear cycle is not re-detected afterwards.
   always_comb begin
      state_d     = en ? RUN : BASELINE;
      prev_d      = en ? sig : prev_q;
      pending_d   = (pending_q & ~sel) | new_ev;
      valid_d     = sel;
      hit_count_d = hit_sum[HIT_W] ? {HIT_W{1'b1}} : hit_sum[HIT_W-1:0];
`ifdef TOGGLE_COVER_ONCE_EN
      covered_d   = covered_q | new_ev;
`endif
      if (clear) begin
         pending_d   = '0;
         valid_d     = '0;
         hit_count_d = '0;
`ifdef TOGGLE_COVER_ONCE_EN
         covered_d   = '0;
`endif
      end
   end

   // State registers with synchronous active-low reset; reset drops any
   // pending points without emitting them.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= BASELINE;
         prev_q      <= '0;
         pending_q   <= '0;
         valid_q     <= '0;
         hit_count_q <= '0;
`ifdef TOGGLE_COVER_ONCE_EN
         covered_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         pending_q   <= pending_d;
         valid_q     <= valid_d;
         hit_count_q <= hit_count_d;
`ifdef TOGGLE_COVER_ONCE_EN
         covered_q   <= covered_d;
`endif
      end
   end

   assign valid     = valid_q;
   assign busy      = |pending_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Scoreboard bench for toggle_cover_collector (WIDTH=4, MAX_PER_CYCLE=2).
// Stimulus pushes the expected (cycle, valid) pulses; a monitor pops them
// whenever valid is non-zero.
module tb_toggle_cover_collector;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        en;
   logic        clear;
   logic [3:0]  sig;
   logic [7:0]  valid;
   logic        busy;
   logic [15:0] hit_count;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t exp_q[$];

   toggle_cover_collector #(
      .WIDTH         (4),
      .MAX_PER_CYCLE (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .clear     (clear),
      .sig       (sig),
      .valid     (valid),
      .busy      (busy),
      .hit_count (hit_count)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Edge counter used to time-stamp expected pulses.
   always @(posedge clock) cyc = cyc + 1;

   // Compare one observed value against its required value.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Advance n clock edges, leaving time 1 unit past the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drive sig/clear for the next edge and queue any expected pulses,
   // which appear two edges after sampling (one per cycle if split).
   task automatic applyStimulus(input logic [3:0] s, input logic c, input logic [7:0] first, input logic [7:0] second);
      sig   = s;
      clear = c;
      if (first != 8'h00) exp_q.push_back('{cyc: cyc + 2, val: first});
      if (second != 8'h00) exp_q.push_back('{cyc: cyc + 3, val: second});
      tick(1);
      clear = 1'b0;
   endtask

   // Monitor: every non-zero valid must match the head of the scoreboard.
   always @(negedge clock) begin
      if (valid !== 8'h00) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", {24'h0, valid}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("pulse_value", {24'h0, valid}, {24'h0, e.val});
            checkOutput("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      clear = 1'b0;
      sig   = 4'h0;
      tick(2);
      checkOutput("reset_valid", {24'h0, valid}, 32'h0);
      checkOutput("reset_busy", {31'h0, busy}, 32'h0);
      checkOutput("reset_hit", {16'h0, hit_count}, 32'h0);

      // Idle monitoring with a constant signal produces nothing.
      reset = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         checkOutput("idle_busy", {31'h0, busy}, 32'h0);
         checkOutput("idle_hit", {16'h0, hit_count}, 32'h0);
      end

      // Single rise on bit 0.
      applyStimulus(4'h1, 1'b0, 8'h01, 8'h00);
      tick(3);
      checkOutput("single_rise_hit", {16'h0, hit_count}, 32'd1);
      checkOutput("single_rise_busy", {31'h0, busy}, 32'h0);

      // Clear in the cycle a fall is sampled: fall discarded, counter zeroed.
      applyStimulus(4'h0, 1'b1, 8'h00, 8'h00);
      tick(1);
      checkOutput("clear_hit", {16'h0, hit_count}, 32'h0);

      // All four bits rise: four points drained two per cycle.
      applyStimulus(4'hF, 1'b0, 8'h05, 8'h50);
      checkOutput("burst_busy1", {31'h0, busy}, 32'h1);
      tick(1);
      checkOutput("burst_busy2", {31'h0, busy}, 32'h1);
      tick(1);
      checkOutput("burst_busy3", {31'h0, busy}, 32'h0);
      tick(1);
      checkOutput("burst_hit", {16'h0, hit_count}, 32'd4);

      // Bit 0 toggles 0->1->0->1 after a clear.
      applyStimulus(4'h0, 1'b1, 8'h00, 8'h00);
      tick(1);
      checkOutput("clear2_hit", {16'h0, hit_count}, 32'h0);
      applyStimulus(4'h1, 1'b0, 8'h01, 8'h00);
      tick(3);
      applyStimulus(4'h0, 1'b0, 8'h02, 8'h00);
      tick(3);
`ifdef TOGGLE_COVER_ONCE_EN
      applyStimulus(4'h1, 1'b0, 8'h00, 8'h00);
      tick(3);
      checkOutput("repeat_hit", {16'h0, hit_count}, 32'd2);
`else
      applyStimulus(4'h1, 1'b0, 8'h01, 8'h00);
      tick(3);
      checkOutput("repeat_hit", {16'h0, hit_count}, 32'd3);
`endif

      // Clear coinciding with a 0x0->0x3 toggle suppresses it entirely.
      applyStimulus(4'h0, 1'b1, 8'h00, 8'h00);
      tick(1);
      applyStimulus(4'h3, 1'b1, 8'h00, 8'h00);
      tick(4);
      checkOutput("clear_new_busy", {31'h0, busy}, 32'h0);
      checkOutput("clear_new_hit", {16'h0, hit_count}, 32'h0);

      // Two falls at once fit in a single cycle.
      applyStimulus(4'h0, 1'b0, 8'h0A, 8'h00);
      tick(4);
      checkOutput("double_fall_hit", {16'h0, hit_count}, 32'd2);

      // Reset while 0x50 is still pending drops it.
      applyStimulus(4'hF, 1'b0, 8'h05, 8'h00);
      tick(1);
      reset = 1'b0;
      tick(1);
      checkOutput("midreset_valid", {24'h0, valid}, 32'h0);
      checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
      checkOutput("midreset_hit", {16'h0, hit_count}, 32'h0);
      reset = 1'b1;
      tick(6);
      checkOutput("post_reset_busy", {31'h0, busy}, 32'h0);
      checkOutput("post_reset_hit", {16'h0, hit_count}, 32'h0);

      // Every queued pulse must have been observed.
      checkOutput("scoreboard_empty", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toggle_cover_collector.md
TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of monitored signal bits.
REQ-002 SHALL have parameter MAX_PER_CYCLE, default 2, maximum cover events emitted per cycle.
REQ-003 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, monitoring enable.
REQ-006 SHALL have port clear, input, 1, one-cycle flush of pending and covered state.
REQ-007 SHALL have port sig, input, WIDTH, monitored signal vector.
REQ-008 SHALL have port valid, output, 2*WIDTH, cover pulses; valid[2i] = rise of sig[i], valid[2i+1] = fall of sig[i]; feeds downstream toggle reporters bit-pair-wise.
REQ-009 SHALL have port busy, output, 1, high while any event is pending.
REQ-010 SHALL have port hit_count, output, 16, total events emitted.

Function
REQ-011 SHALL implement two states, BASELINE and RUN.
REQ-012 In BASELINE with en=1, the block SHALL capture prev<=sig, move to RUN and detect no event that cycle.
REQ-013 In RUN, the block SHALL compute rise=sig&~prev and fall=~sig&prev, and SHALL update prev<=sig every cycle.
REQ-014 With en=0 in any state, the block SHALL go to BASELINE next cycle, detect nothing and keep draining pending.
REQ-015 Pending update SHALL be pending<=(pending&~sel)|new, where sel is the registered pick from pending.
REQ-016 New events SHALL be interleaved rise/fall into 2*WIDTH positions.
REQ-017 sel SHALL be the up-to-MAX_PER_CYCLE lowest-index set bits of the current pending register.
REQ-018 valid SHALL be registered with valid<=sel.
REQ-019 Latency SHALL be: toggle sampled at edge k, pending at k, valid high for exactly one cycle after edge k+1, if within budget.
REQ-020 An event already pending SHALL merge with a repeat event; it is emitted once and the merge is not counted.
REQ-021 Events at the same position in new and sel in the same cycle SHALL leave the bit set, so it is re-emitted.
REQ-022 busy SHALL equal |pending.
REQ-023 hit_count SHALL add popcount(valid) each cycle and saturate at 0xFFFF.
REQ-024 clear=1 SHALL zero pending, valid, covered and hit_count next cycle.
REQ-025 clear SHALL override same-cycle new events.
REQ-026 clear SHALL leave the state and prev unchanged.

Reset
REQ-027 reset=0 at an edge SHALL zero prev, pending, valid, covered and hit_count, and SHALL set state BASELINE; busy is then 0.
REQ-028 Reset mid-drain SHALL discard all pending events without emitting them.

Configuration
REQ-029 Macro TOGGLE_COVER_ONCE_EN defined: the block SHALL keep a 2*WIDTH covered mask, set when an event enters pending, and mask new events with ~covered, so each point is emitted at most once until clear/reset.
REQ-030 Macro TOGGLE_COVER_ONCE_EN absent: the covered register SHALL NOT exist, and every detected toggle SHALL be queued.

Structure
REQ-031 Package toggle_cover_pkg SHALL hold the state enum (BASELINE, RUN), the WIDTH/MAX_PER_CYCLE defaults and the hit_count width constant.
REQ-032 Sub-module toggle_pick_lowest SHALL provide combinational selection of up to N lowest set bits of a vector; it is the only sub-module.

Verification (WIDTH=4, MAX_PER_CYCLE=2)
REQ-033 Reset, en=1, sig=0x0 held 20 cycles -> valid=0, busy=0, hit_count=0 throughout.
REQ-034 After baseline sig 0x0->0x1 -> valid=0x01 for one cycle, 2 edges after the change; hit_count=1.
REQ-035 sig 0x0->0xF -> valid=0x05 then 0x50 on consecutive cycles; busy falls after; hit_count=4.
REQ-036 sig[0] 0->1->0->1 spaced 4 cycles: with macro -> bit0 and bit1 pulse once each, hit_count=2; without macro -> bit0 pulses twice, hit_count=3.
REQ-037 clear asserted in same cycle that sig 0x0->0x3 is sampled -> no valid pulse, busy=0, hit_count=0.
REQ-038 Reset asserted while 0x50 pending, then en=1 -> pending lost, valid=0; first post-reset cycle is baseline with no event despite sig=0xF.
